// File: rtl/fft_in_buf.sv
// fft_in_buf: ping-pong input loader for the 64-point FFT core.
//
// Collects a serial stream of complex samples under a valid/ready handshake
// into one of two banks. A completed bank is issued to the core with a single
// val_o pulse and its contents are held on the flat frame buses until the core
// returns done_i. The other bank keeps filling in the meantime.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_val_i             input sample valid
//   in_re_i, in_im_i     sample real / imaginary parts
//   in_rdy_o             current write bank is empty and can take a sample
//   done_i               core finished the issued frame (one-cycle pulse)
//   val_o                frame start pulse, one cycle wide
//   fft_data_re_o/_im_o  frame from the read bank, sample k at [k*DATA_WID +: DATA_WID]
//   busy_o               a frame is issued and done_i has not yet returned
module fft_in_buf #(
  parameter int FFT_LEN  = 64,
  parameter int DATA_WID = 16,
  parameter int CNT_WID  = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_val_i,
  input  logic [DATA_WID-1:0]         in_re_i,
  input  logic [DATA_WID-1:0]         in_im_i,
  output logic                        in_rdy_o,
  input  logic                        done_i,
  output logic                        val_o,
  output logic [FFT_LEN*DATA_WID-1:0] fft_data_re_o,
  output logic [FFT_LEN*DATA_WID-1:0] fft_data_im_o,
  output logic                        busy_o
);

  localparam logic [CNT_WID-1:0] LAST_IDX = CNT_WID'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY  = 2'd0,
    BANK_FULL   = 2'd1,
    BANK_ISSUED = 2'd2
  } bank_st_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } rd_st_e;

  bank_st_e            bank_st_r    [2];
  bank_st_e            bank_st_nx_s [2];
  logic                wr_bank_r;
  logic                rd_bank_r;
  logic [CNT_WID-1:0]  wr_cnt_r;
  rd_st_e              state_r;
  rd_st_e              state_nx_s;
  logic                val_r;
  logic                busy_r;
  logic [DATA_WID-1:0] mem_re_r [2][FFT_LEN];
  logic [DATA_WID-1:0] mem_im_r [2][FFT_LEN];

  logic in_rdy_s;
  logic accept_s;
  logic frame_done_s;
  logic issue_s;
  logic free_s;

  // Write-side handshake decode; ready depends on registered bank state only.
  always_comb begin
    in_rdy_s     = (bank_st_r[wr_bank_r] == BANK_EMPTY);
    accept_s     = in_val_i & in_rdy_s;
    frame_done_s = accept_s & (wr_cnt_r == LAST_IDX);
  end

  // Read FSM next state. A frame completing into the read bank on this very
  // edge is treated as already full, so val_o follows the last accept directly.
  always_comb begin
    state_nx_s = state_r;
    issue_s    = 1'b0;
    free_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((bank_st_r[rd_bank_r] == BANK_FULL) ||
            (frame_done_s && (wr_bank_r == rd_bank_r))) begin
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s    = 1'b1;
        state_nx_s = ST_BUSY;
      end
      ST_BUSY: begin
        if (done_i) begin
          free_s     = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Per-bank status update. A bank being filled is never the one being
  // issued or freed, so at most one of these terms applies to a given bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_nx_s[b] = bank_st_r[b];
      if (frame_done_s && (wr_bank_r == b[0])) begin
        bank_st_nx_s[b] = BANK_FULL;
      end else if (issue_s && (rd_bank_r == b[0])) begin
        bank_st_nx_s[b] = BANK_ISSUED;
      end else if (free_s && (rd_bank_r == b[0])) begin
        bank_st_nx_s[b] = BANK_EMPTY;
      end else begin
        bank_st_nx_s[b] = bank_st_r[b];
      end
    end
  end

  // Control state: FSM, bank status, bank pointers, write index, output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bank_st_r[0] <= BANK_EMPTY;
      bank_st_r[1] <= BANK_EMPTY;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      wr_cnt_r     <= '0;
      val_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      bank_st_r[0] <= bank_st_nx_s[0];
      bank_st_r[1] <= bank_st_nx_s[1];
      if (accept_s) begin
        wr_cnt_r <= wr_cnt_r + CNT_WID'(1);
      end
      if (frame_done_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
      if (free_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
      val_r  <= (state_nx_s == ST_ISSUE);
      busy_r <= (state_nx_s == ST_BUSY);
    end
  end

  // Sample storage: natural arrival order, cleared on reset so no stale frame
  // is ever visible on the output buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < FFT_LEN; k++) begin
          mem_re_r[b][k] <= '0;
          mem_im_r[b][k] <= '0;
        end
      end
    end else if (accept_s) begin
      mem_re_r[wr_bank_r][wr_cnt_r] <= in_re_i;
      mem_im_r[wr_bank_r][wr_cnt_r] <= in_im_i;
    end
  end

  // Frame buses are a pure mux of the read bank's flops; adding an output
  // register stage would duplicate the whole frame store.
  always_comb begin
    fft_data_re_o = '0;
    fft_data_im_o = '0;
    for (int k = 0; k < FFT_LEN; k++) begin
      fft_data_re_o[k*DATA_WID +: DATA_WID] = mem_re_r[rd_bank_r][k];
      fft_data_im_o[k*DATA_WID +: DATA_WID] = mem_im_r[rd_bank_r][k];
    end
  end

  assign in_rdy_o = in_rdy_s;
  assign val_o    = val_r;
  assign busy_o   = busy_r;

endmodule

// File: doc/fft_in_buf.md
Name: fft_in_buf

Overview:
- Upstream loader for the 64-point FFT core.
- Accepts a serial stream of complex samples under a valid/ready handshake and assembles them into 64-sample parallel frames.
- Presents each frame on flat buses with a one-cycle start pulse, then holds it stable until the core reports done.
- Ping-pong (two-bank) storage lets the next frame fill while the core computes the current one.

Parameters:
- FFT_LEN, 64, samples per frame; equals `FFT_LEN. Power of two.
- DATA_WID, 16, bits per real or imaginary sample; equals `DATA_WID.
- CNT_WID, 6, log2(FFT_LEN); width of the write index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_val_i  input  1  input sample valid.
- in_re_i  input  DATA_WID  real part of the input sample.
- in_im_i  input  DATA_WID  imaginary part of the input sample.
- in_rdy_o  output  1  buffer can accept a sample this cycle.
- done_i  input  1  core finished the current frame; one-cycle pulse.
- val_o  output  1  frame start pulse to the core; one cycle wide.
- fft_data_re_o  output  FFT_LEN*DATA_WID  real frame; sample k at bits [k*DATA_WID +: DATA_WID].
- fft_data_im_o  output  FFT_LEN*DATA_WID  imaginary frame; same packing as fft_data_re_o.
- busy_o  output  1  a frame has been issued and done_i has not yet returned.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_cnt=0; FSM in IDLE.
  - val_o=0, busy_o=0, fft_data_*_o=0 (bank storage cleared).
  - in_rdy_o=1 (write bank is empty).
- Bank state: each bank is EMPTY, FULL or ISSUED.
- Write side:
  - in_rdy_o = (bank[wr_bank] == EMPTY); combinational from registered state only, with no dependence on in_val_i.
  - A sample is accepted when in_val_i & in_rdy_o. It is stored at index wr_cnt of bank[wr_bank], and wr_cnt increments.
  - Samples are packed in natural arrival order; no bit reversal here (the core performs its own ordering).
  - On accepting sample FFT_LEN-1: bank[wr_bank] becomes FULL, wr_bank toggles, and wr_cnt wraps to 0, all on the same edge.
  - When both banks are not EMPTY, in_rdy_o=0 and the source stalls. No sample is ever dropped or overwritten.
- Read FSM (states IDLE, ISSUE, BUSY):
  - IDLE: if bank[rd_bank] is FULL, or becomes FULL on this edge, go to ISSUE.
  - ISSUE: val_o=1 for exactly this cycle. bank[rd_bank] becomes ISSUED. Go to BUSY.
  - BUSY: busy_o=1. On done_i, bank[rd_bank] becomes EMPTY, rd_bank toggles, and the FSM returns to IDLE.
- Latency and output timing:
  - val_o is high in the cycle immediately after the edge that captured the 64th sample, provided the FSM was IDLE.
  - After done_i, the earliest next val_o is 2 cycles later (IDLE then ISSUE). This guarantees the core is back in idle.
- fft_data_re_o / fft_data_im_o:
  - Always driven from bank[rd_bank].
  - Stable from the val_o cycle through the done_i cycle inclusive. The core samples the frame in the val_o cycle.
- Simultaneous events:
  - done_i coincides with the 64th write into the other bank: the free occurs, then IDLE, then ISSUE next cycle.
  - done_i coincides with a write into the freed bank: impossible, because the freed bank was not the write bank.
  - Writes to bank[wr_bank] never alter bank[rd_bank] outputs.
- Ignored inputs:
  - done_i is ignored in IDLE and ISSUE.
  - in_re_i / in_im_i are ignored when not accepted.
- Reset mid-operation:
  - Any partial or full frame is discarded.
  - Outputs return to reset values asynchronously; no val_o is issued for pre-reset data.
- Area: storage is 2*FFT_LEN*2*DATA_WID flops. There is no arithmetic; wr_cnt is CNT_WID bits and wraps modulo FFT_LEN.

Test Plan:
- Reset, then stream samples with re=k, im=-k for k=0..63 at continuous in_val_i.
  - val_o pulses one cycle after the 64th accept.
  - fft_data_re_o[k*16 +: 16]=k and fft_data_im_o slice k = -k for all k.
  - busy_o=1 from the next cycle.
- Stream 130 samples back-to-back with no done_i.
  - Frames 0 and 1 are accepted; in_rdy_o drops after sample 127.
  - Samples 128 and 129 are held, not accepted, until done_i.
  - Frame-0 outputs stay unchanged throughout.
- From the previous state, pulse done_i.
  - in_rdy_o=1 the next cycle.
  - val_o two cycles after done_i with frame 1 data (values 64..127).
  - Held samples 128 and 129 then land at indices 0 and 1 of the new write bank.
- Assert done_i in the same cycle as the 64th accept of the next frame.
  - Exactly one val_o, 2 cycles later, with the new frame.
  - No lost or duplicated frames over 4 consecutive frames.
- Toggle in_val_i randomly (50%) over 3 frames with core done_i latency of 20 cycles.
  - Every frame is emitted in order and bit-exact; val_o is always one cycle wide.
- Assert rst_n=0 at sample 30 of a frame while busy_o=1.
  - All outputs are 0 and in_rdy_o=1 after release.
  - A fresh 64-sample frame produces a correct val_o with no stale data.
